// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and the ALU it drives:
// FSM state encoding, ALU control codes and the operand width.
package alu_mul_seq_pkg;

  localparam int MUL_W = 32;

  // ALU control decode; ADDU and SLTU are the only codes the multiplier uses.
  localparam logic [2:0] ALU_OP_ADDU = 3'b000;
  localparam logic [2:0] ALU_OP_SUBU = 3'b001;
  localparam logic [2:0] ALU_OP_AND  = 3'b010;
  localparam logic [2:0] ALU_OP_OR   = 3'b011;
  localparam logic [2:0] ALU_OP_XOR  = 3'b100;
  localparam logic [2:0] ALU_OP_SLTU = 3'b101;
  localparam logic [2:0] ALU_OP_SLT  = 3'b110;
  localparam logic [2:0] ALU_OP_ADD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ITER  = 3'd1,
    ST_ADD   = 3'd2,
    ST_CARRY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// 32-bit combinational ALU shared by the execute stage.
// Ports:
//   A, B     in  32  operands
//   ALUctr   in  3   operation select (ALU_OP_* in alu_mul_seq_pkg)
//   Result   out 32  operation result
//   Overflow out 1   signed overflow (ALU_OP_ADD only)
//   Z        out 1   Result is zero
module ALU
  import alu_mul_seq_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUctr,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        Z
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = A + B;
  assign w_diff = A - B;

  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    case (ALUctr)
      ALU_OP_ADDU: Result = w_sum;
      ALU_OP_SUBU: Result = w_diff;
      ALU_OP_AND:  Result = A & B;
      ALU_OP_OR:   Result = A | B;
      ALU_OP_XOR:  Result = A ^ B;
      ALU_OP_SLTU: Result = {31'b0, (A < B)};
      ALU_OP_SLT:  Result = {31'b0, ($signed(A) < $signed(B))};
      ALU_OP_ADD: begin
        Result   = w_sum;
        Overflow = (A[31] == B[31]) && (w_sum[31] != A[31]);
      end
      default: Result = '0;
    endcase
  end

  assign Z = (Result == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 unsigned multiplier that borrows the execute-stage
// ALU for shift-and-add iterations. Handshake: start / busy / done.
// Ports:
//   clk      in  1   clock
//   rst_n    in  1   async active-low reset
//   start    in  1   request, sampled only in IDLE
//   mcand    in  32  multiplicand (captured on accepted start)
//   mplier   in  32  multiplier (captured on accepted start)
//   busy     out 1   high in every state but IDLE
//   done     out 1   one-cycle pulse, product valid in that cycle
//   product  out 64  result register
// Optional feature: define ALU_MUL_SEQ_EARLY_EXIT_EN to leave ITER as soon
// as no multiplier bits remain, aligning P with a single logical shift.
//
// state | meaning
// IDLE  | waiting for start, ALU idle
// ITER  | inspect MR[0]; zero bits are shifted in place
// ADD   | S <= hi + M through the ALU
// CARRY | carry = (S < M) through the ALU, shift sum into P
// DONE  | product valid, done pulse
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [5:0] CNT_LAST = 6'(MUL_W);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_m;
  logic [31:0] r_mr;
  logic [63:0] r_p;
  logic [31:0] r_s;
  logic [5:0]  r_cnt;
  logic [63:0] r_product;

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_ctr;
  logic [31:0] w_alu_res;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  // Remaining (32-cnt) shifts are all zero-steps, so do them at once.
  logic [63:0] w_p_early;
  assign w_p_early = r_p >> (7'd32 - {1'b0, r_cnt});
`endif

  ALU u_alu (
    .A        (w_alu_a),
    .B        (w_alu_b),
    .ALUctr   (w_alu_ctr),
    .Result   (w_alu_res),
    .Overflow (),
    .Z        ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alu_a     = '0;
    w_alu_b     = '0;
    w_alu_ctr   = ALU_OP_ADDU;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ITER;
      ST_ITER: begin
        if (r_cnt == CNT_LAST)  w_state_nxt = ST_DONE;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        else if (r_mr == '0)    w_state_nxt = ST_DONE;
`endif
        else if (r_mr[0])       w_state_nxt = ST_ADD;
      end
      ST_ADD: begin
        w_alu_a     = r_p[63:32];
        w_alu_b     = r_m;
        w_state_nxt = ST_CARRY;
      end
      ST_CARRY: begin
        // Unsigned sum below M means the add wrapped: that is the carry-out.
        w_alu_a     = r_s;
        w_alu_b     = r_m;
        w_alu_ctr   = ALU_OP_SLTU;
        w_state_nxt = ST_ITER;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Product is loaded on entry to DONE so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_mr      <= '0;
      r_p       <= '0;
      r_s       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_m   <= mcand;
            r_mr  <= mplier;
            r_p   <= '0;
            r_cnt <= '0;
          end
        end
        ST_ITER: begin
          if (r_cnt == CNT_LAST) begin
            r_product <= r_p;
          end
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
          else if (r_mr == '0) begin
            r_p       <= w_p_early;
            r_product <= w_p_early;
          end
`endif
          else if (!r_mr[0]) begin
            r_p   <= {1'b0, r_p[63:1]};
            r_mr  <= r_mr >> 1;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_ADD: r_s <= w_alu_res;
        ST_CARRY: begin
          r_p   <= {w_alu_res[0], r_s, r_p[31:1]};
          r_mr  <= r_mr >> 1;
          r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: hand-computed products and latencies,
// handshake behaviour, ignored start pulses and asynchronous reset abort.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  localparam bit LAT_CHK = 1'b0;
`else
  localparam bit LAT_CHK = 1'b1;
`endif

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one multiply starting in the current (IDLE) cycle and follows it
  // through DONE plus the IDLE cycle after it. lat counts edges after the
  // start-accepting edge up to the edge that enters DONE.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_lat, input bit pulse_mid);
    int lat;
    bit seen;
    bit busy_ok;
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands are captured; later changes must have no effect.
    mcand = 32'hA5A5_5A5A;
    mplier = 32'h3C3C_C3C3;
    chk({tag, "_busy_rise"}, {63'b0, busy}, 64'd1);
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 200) begin
      start = (pulse_mid && (lat == 5 || lat == 20));
      @(posedge clk); lat++; #1;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
    if (LAT_CHK) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_held"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, "_product"}, product, exp_p);
    // start coinciding with done must be ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse_end"}, {63'b0, done}, 64'd0);
    chk({tag, "_start_at_done_ignored"}, {63'b0, busy}, 64'd0);
    chk({tag, "_product_hold"}, product, exp_p);
  endtask

  initial begin
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mul("m3x5", 32'd3, 32'd5, 64'h0F, 37, 1'b0);
    run_mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 97, 1'b0);
    run_mul("mzero", 32'h1234, 32'd0, 64'd0, 33, 1'b0);
    run_mul("m7x9_pulses", 32'd7, 32'd9, 64'd63, 37, 1'b1);
    run_mul("m7x1", 32'd7, 32'd1, 64'd7, 35, 1'b0);

    // Abort a 6x7 multiply with a one-cycle reset.
    mcand = 32'd6;
    mplier = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_product", product, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_product", product, 64'd0);

    run_mul("m2x2", 32'd2, 32'd2, 64'd4, 35, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
